// File: rtl/fetch_issue_queue_pkg.sv
// Shared widths, the buffered-line record and slot extraction for the fetch
// issue queue (slot 0 is the most significant word of a line).
package fetch_issue_queue_pkg;

   localparam int AddressWidth            = 64;
   localparam int InstructionWidth        = 32;
   localparam int PidSize                 = 20;
   localparam int TidSize                 = 16;
   localparam int InstructionCounterWidth = 64;
   localparam int LineInsts               = 4;
   localparam int QueueDepth              = 4;

   localparam int LineWidth  = LineInsts * InstructionWidth;
   localparam int SlotWidth  = $clog2(LineInsts);
   localparam int PtrWidth   = $clog2(QueueDepth);
   localparam int CountWidth = $clog2(QueueDepth) + 1;

   localparam logic [SlotWidth-1:0] LastSlot = SlotWidth'(LineInsts - 1);

   typedef struct packed {
      logic [LineWidth-1:0]    line;
      logic [AddressWidth-1:0] addr;
      logic [SlotWidth-1:0]    start_slot;
      logic                    is64;
      logic [PidSize-1:0]      pid;
      logic [TidSize-1:0]      tid;
   } line_entry_t;

   localparam int EntryWidth = $bits(line_entry_t);

   function automatic logic [InstructionWidth-1:0] get_slot(
      input logic [LineWidth-1:0] line,
      input logic [SlotWidth-1:0] slot
   );
      logic [LineWidth-1:0] shifted;
      shifted = line << (InstructionWidth * int'(slot));
      return shifted[LineWidth-1 -: InstructionWidth];
   endfunction

endpackage

// File: rtl/fetch_issue_queue_line_fifo.sv
// Synchronous line FIFO between fetch and the issue register; a count register
// separates full from empty since the pointers wrap modulo the depth.
module fetch_line_fifo
   import fetch_issue_queue_pkg::*;
(
   input  logic                  clock_i,
   input  logic                  reset_i,
   input  logic                  push_i,
   input  logic                  pop_i,
   input  logic                  flush_i,
   input  logic [EntryWidth-1:0] data_i,
   output logic [EntryWidth-1:0] head_o,
   output logic                  full_o,
   output logic                  empty_o
);

   logic [EntryWidth-1:0] mem_q [QueueDepth];
   logic [PtrWidth-1:0]   wptr_q, wptr_d;
   logic [PtrWidth-1:0]   rptr_q, rptr_d;
   logic [CountWidth-1:0] count_q, count_d;
   logic                  do_push;
   logic                  do_pop;

   assign full_o  = (count_q == CountWidth'(QueueDepth));
   assign empty_o = (count_q == '0);
   assign head_o  = mem_q[rptr_q];

   assign do_push = push_i && !full_o && !flush_i;
   assign do_pop  = pop_i && !empty_o && !flush_i;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (flush_i) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (do_push) wptr_d = wptr_q + 1'b1;
         if (do_pop)  rptr_d = rptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clock_i) begin
      if (do_push) mem_q[wptr_q] <= data_i;
   end

endmodule

// File: rtl/fetch_issue_queue.sv
// Buffers fetched cache lines and issues one instruction per cycle to decode,
// tagging each with a unique major ID that survives flushes.
module fetch_issue_queue
   import fetch_issue_queue_pkg::*;
(
   input  logic                               clock_i,
   input  logic                               reset_i,
   input  logic                               flush_i,
   input  logic                               lineValid_i,
   output logic                               lineReady_o,
   input  logic [LineWidth-1:0]               line_i,
   input  logic [AddressWidth-1:0]            lineAddress_i,
   input  logic [SlotWidth-1:0]               lineStartSlot_i,
   input  logic                               is64Bit_i,
   input  logic [PidSize-1:0]                 pid_i,
   input  logic [TidSize-1:0]                 tid_i,
   input  logic                               stall_i,
   output logic                               enable_o,
   output logic [InstructionWidth-1:0]        instruction_o,
   output logic [AddressWidth-1:0]            instructionAddress_o,
   output logic                               is64Bit_o,
   output logic [PidSize-1:0]                 instructionPid_o,
   output logic [TidSize-1:0]                 instructionTid_o,
   output logic [InstructionCounterWidth-1:0] instructionMajId_o
);

   line_entry_t           push_entry;
   line_entry_t           head;
   logic [EntryWidth-1:0] head_w;
   logic                  fifo_full;
   logic                  fifo_empty;

   logic                               alive_q;
   logic                               enable_q;
   logic [InstructionWidth-1:0]        instr_q;
   logic [AddressWidth-1:0]            addr_q;
   logic                               is64_q;
   logic [PidSize-1:0]                 pid_q;
   logic [TidSize-1:0]                 tid_q;
   logic [InstructionCounterWidth-1:0] majid_q;
   logic [InstructionCounterWidth-1:0] ctr_q;
   logic [SlotWidth-1:0]               slot_ptr_q;
   logic                               head_new_q;

   logic                 advance;
   logic                 load;
   logic                 push;
   logic                 pop;
   logic [SlotWidth-1:0] cur_slot;

   assign push_entry = '{line:       line_i,
                         addr:       lineAddress_i,
                         start_slot: lineStartSlot_i,
                         is64:       is64Bit_i,
                         pid:        pid_i,
                         tid:        tid_i};
   assign head = head_w;

   // alive_q keeps lineReady_o low while in reset and until the first edge after.
   assign lineReady_o = alive_q && !fifo_full;
   assign push        = lineValid_i && lineReady_o && !flush_i;

   assign advance  = !enable_q || !stall_i;
   assign load     = advance && !fifo_empty && !flush_i;
   // A freshly promoted head starts at its own start slot rather than slot_ptr_q.
   assign cur_slot = head_new_q ? head.start_slot : slot_ptr_q;
   assign pop      = load && (cur_slot == LastSlot);

   fetch_line_fifo u_line_fifo (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (flush_i),
      .data_i  (push_entry),
      .head_o  (head_w),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         alive_q    <= 1'b0;
         enable_q   <= 1'b0;
         instr_q    <= '0;
         addr_q     <= '0;
         is64_q     <= 1'b0;
         pid_q      <= '0;
         tid_q      <= '0;
         majid_q    <= '0;
         ctr_q      <= '0;
         slot_ptr_q <= '0;
         head_new_q <= 1'b1;
      end else begin
         alive_q <= 1'b1;
         if (flush_i) begin
            enable_q   <= 1'b0;
            slot_ptr_q <= '0;
            head_new_q <= 1'b1;
         end else if (advance) begin
            if (load) begin
               enable_q <= 1'b1;
               instr_q  <= get_slot(head.line, cur_slot);
               addr_q   <= head.addr + (AddressWidth'(cur_slot) << 2);
               is64_q   <= head.is64;
               pid_q    <= head.pid;
               tid_q    <= head.tid;
               majid_q  <= ctr_q;
               ctr_q    <= ctr_q + 1'b1;
               if (pop) begin
                  slot_ptr_q <= '0;
                  head_new_q <= 1'b1;
               end else begin
                  slot_ptr_q <= cur_slot + 1'b1;
                  head_new_q <= 1'b0;
               end
            end else begin
               enable_q <= 1'b0;
            end
         end
      end
   end

   assign enable_o             = enable_q;
   assign instruction_o        = instr_q;
   assign instructionAddress_o = addr_q;
   assign is64Bit_o            = is64_q;
   assign instructionPid_o     = pid_q;
   assign instructionTid_o     = tid_q;
   assign instructionMajId_o   = majid_q;

endmodule

// File: tb/tb_fetch_issue_queue.sv
// Scoreboard bench: accepted lines expand into expected instructions; a negedge
// monitor compares each newly issued instruction, stall holds and flush bubbles.
module tb_fetch_issue_queue;

   logic          clock_i = 1'b0;
   logic          reset_i = 1'b0;
   logic          flush_i;
   logic          lineValid_i;
   logic          lineReady_o;
   logic [127:0]  line_i;
   logic [63:0]   lineAddress_i;
   logic [1:0]    lineStartSlot_i;
   logic          is64Bit_i;
   logic [19:0]   pid_i;
   logic [15:0]   tid_i;
   logic          stall_i;
   logic          enable_o;
   logic [31:0]   instruction_o;
   logic [63:0]   instructionAddress_o;
   logic          is64Bit_o;
   logic [19:0]   instructionPid_o;
   logic [15:0]   instructionTid_o;
   logic [63:0]   instructionMajId_o;

   fetch_issue_queue dut (
      .clock_i              (clock_i),
      .reset_i              (reset_i),
      .flush_i              (flush_i),
      .lineValid_i          (lineValid_i),
      .lineReady_o          (lineReady_o),
      .line_i               (line_i),
      .lineAddress_i        (lineAddress_i),
      .lineStartSlot_i      (lineStartSlot_i),
      .is64Bit_i            (is64Bit_i),
      .pid_i                (pid_i),
      .tid_i                (tid_i),
      .stall_i              (stall_i),
      .enable_o             (enable_o),
      .instruction_o        (instruction_o),
      .instructionAddress_o (instructionAddress_o),
      .is64Bit_o            (is64Bit_o),
      .instructionPid_o     (instructionPid_o),
      .instructionTid_o     (instructionTid_o),
      .instructionMajId_o   (instructionMajId_o)
   );

   always #5 clock_i = ~clock_i;

   typedef struct {
      logic [31:0] instr;
      logic [63:0] addr;
      logic        is64;
      logic [19:0] pid;
      logic [15:0] tid;
   } exp_t;

   exp_t        exp_q[$];
   int          n_cmp  = 0;
   int          n_fail = 0;
   logic [63:0] exp_id = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
      end
   endtask

   // Reference: a line expands to words start..3, slot k holding bits [127-32k -: 32].
   task automatic model_push();
      for (int s = int'(lineStartSlot_i); s < 4; s++) begin
         logic [127:0] t;
         exp_t e;
         t = line_i >> (32 * (3 - s));
         e.instr = t[31:0];
         e.addr  = lineAddress_i + 64'(4 * s);
         e.is64  = is64Bit_i;
         e.pid   = pid_i;
         e.tid   = tid_i;
         exp_q.push_back(e);
      end
   endtask

   // Monitor state from the previous negedge.
   logic        p_en, p_stall, p_flush;
   logic [31:0] s_instr;
   logic [63:0] s_addr, s_maj;

   always @(negedge clock_i) begin
      if (!reset_i) begin
         exp_q.delete();
         exp_id  = '0;
         p_en    = 1'b0;
         p_stall = 1'b0;
         p_flush = 1'b0;
      end else begin
         if (p_flush) begin
            chk("flush_bubble", 64'(enable_o), 64'd0);
         end else if (p_en && p_stall) begin
            chk("stall_en", 64'(enable_o), 64'd1);
            chk("stall_instr", 64'(instruction_o), 64'(s_instr));
            chk("stall_addr", instructionAddress_o, s_addr);
            chk("stall_majid", instructionMajId_o, s_maj);
         end else if (enable_o) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_issue", 64'(instructionAddress_o), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("instr", 64'(instruction_o), 64'(e.instr));
               chk("addr", instructionAddress_o, e.addr);
               chk("attrs", 64'({is64Bit_o, instructionPid_o, instructionTid_o}),
                   64'({e.is64, e.pid, e.tid}));
               chk("majid", instructionMajId_o, exp_id);
            end
            exp_id = exp_id + 64'd1;
         end
         s_instr = instruction_o;
         s_addr  = instructionAddress_o;
         s_maj   = instructionMajId_o;
         p_en    = enable_o;
         p_stall = stall_i;
         p_flush = flush_i;
         if (flush_i) exp_q.delete();
      end
   end

   task automatic step(output bit hs);
      @(negedge clock_i);
      hs = lineValid_i && lineReady_o && !flush_i;
      if (hs) model_push();
      @(posedge clock_i);
      #1;
      if (hs) lineValid_i = 1'b0;
   endtask

   task automatic offer(input logic [127:0] ln, input logic [63:0] a, input logic [1:0] st);
      line_i          = ln;
      lineAddress_i   = a;
      lineStartSlot_i = st;
      is64Bit_i       = 1'($urandom);
      pid_i           = 20'($urandom);
      tid_i           = 16'($urandom);
      lineValid_i     = 1'b1;
   endtask

   task automatic push_line(input logic [127:0] ln, input logic [63:0] a, input logic [1:0] st);
      bit hs;
      int n;
      offer(ln, a, st);
      hs = 0;
      n  = 0;
      while (!hs && n < 100) begin
         step(hs);
         n++;
      end
      if (!hs) chk("push_timeout", 64'd0, 64'd1);
   endtask

   task automatic drain();
      bit hs;
      int n;
      n = 0;
      while (!(exp_q.size() == 0 && !enable_o && !lineValid_i) && n < 400) begin
         step(hs);
         n++;
      end
      chk("drain_left", 64'(exp_q.size()), 64'd0);
   endtask

   function automatic logic [127:0] rnd_line();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit          hs;
      int          n;
      logic [63:0] f_id;

      flush_i = 0; lineValid_i = 0; stall_i = 0;
      line_i = '0; lineAddress_i = '0; lineStartSlot_i = '0;
      is64Bit_i = 0; pid_i = '0; tid_i = '0;

      // Reset
      repeat (2) @(posedge clock_i);
      #1;
      chk("rst_enable", 64'(enable_o), 64'd0);
      chk("rst_majid", instructionMajId_o, 64'd0);
      chk("rst_ready", 64'(lineReady_o), 64'd0);
      reset_i = 1'b1;
      chk("ready_before_edge", 64'(lineReady_o), 64'd0);
      @(posedge clock_i);
      #1;
      chk("ready_after_edge", 64'(lineReady_o), 64'd1);

      // Single line, latency and IDs 0..3
      offer({32'h38600001, 32'h38800002, 32'h7C632214, 32'h4E800020}, 64'h1000, 2'd0);
      step(hs);
      chk("push_accepted", 64'(hs), 64'd1);
      chk("latency_n", 64'(enable_o), 64'd0);
      step(hs);
      chk("latency_n1", 64'(enable_o), 64'd1);
      chk("first_word", 64'(instruction_o), 64'h38600001);
      chk("first_majid", instructionMajId_o, 64'd0);
      drain();

      // Mid-line entry
      push_line(rnd_line(), 64'h2000, 2'd2);
      drain();
      chk("midline_count", exp_id, 64'd6);

      // Stall while slot 1 is shown
      push_line(rnd_line(), 64'h3000, 2'd0);
      n = 0;
      while (!(enable_o && instructionAddress_o == 64'h3004) && n < 20) begin
         step(hs);
         n++;
      end
      chk("reach_slot1", instructionAddress_o, 64'h3004);
      stall_i = 1;
      repeat (3) step(hs);
      chk("stalled_addr", instructionAddress_o, 64'h3004);
      stall_i = 0;
      step(hs);
      chk("after_stall_addr", instructionAddress_o, 64'h3008);
      drain();

      // Full queue under stall
      stall_i = 1;
      for (int i = 0; i < 4; i++) push_line(rnd_line(), 64'h4000 + 64'(i * 16), 2'd0);
      chk("full_ready", 64'(lineReady_o), 64'd0);
      offer(rnd_line(), 64'h5000, 2'd0);
      repeat (3) step(hs);
      chk("fifth_held", 64'(lineValid_i), 64'd1);
      stall_i = 0;
      step(hs);
      step(hs);
      chk("ready_still_low", 64'(lineReady_o), 64'd0);
      step(hs);
      chk("ready_rises", 64'(lineReady_o), 64'd1);
      drain();
      chk("full_total", exp_id, 64'd30);

      // Flush mid-emission with two lines queued behind the head
      push_line(rnd_line(), 64'h6000, 2'd0);
      push_line(rnd_line(), 64'h6010, 2'd0);
      push_line(rnd_line(), 64'h6020, 2'd0);
      f_id = instructionMajId_o;
      flush_i = 1;
      offer(rnd_line(), 64'h7000, 2'd0);
      step(hs);
      chk("flush_drops_push", 64'(hs), 64'd0);
      chk("flush_enable", 64'(enable_o), 64'd0);
      flush_i = 0;
      lineValid_i = 0;
      push_line(rnd_line(), 64'h8000, 2'd0);
      step(hs);
      chk("post_flush_majid", instructionMajId_o, f_id + 64'd1);
      chk("post_flush_addr", instructionAddress_o, 64'h8000);
      drain();

      // Random traffic
      for (int c = 0; c < 1500; c++) begin
         if (!lineValid_i && $urandom_range(0, 99) < 55)
            offer(rnd_line(), {$urandom, $urandom} & ~64'hF, 2'($urandom));
         stall_i = ($urandom_range(0, 99) < 25);
         flush_i = ($urandom_range(0, 99) < 2);
         step(hs);
      end
      stall_i = 0;
      flush_i = 0;
      drain();

      // Reset mid-operation
      push_line(rnd_line(), 64'h9000, 2'd0);
      step(hs);
      #3;
      reset_i = 1'b0;
      #1;
      chk("async_rst_enable", 64'(enable_o), 64'd0);
      chk("async_rst_majid", instructionMajId_o, 64'd0);
      chk("async_rst_ready", 64'(lineReady_o), 64'd0);
      chk("async_rst_instr", 64'(instruction_o), 64'd0);
      @(posedge clock_i);
      #1;
      reset_i = 1'b1;
      lineValid_i = 0;
      step(hs);
      push_line(rnd_line(), 64'hA000, 2'd1);
      drain();
      chk("post_reset_ids", exp_id, 64'd3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
